// File: rtl/motor_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// motor_axi_lite_slave
//
// AXI4-Lite responder for the Bluetooth car motor driver. Four 32-bit RW
// registers sit behind S00_AXI and drive a two-channel PWM plus direction
// outputs for the H-bridge.
//
//   0x0 CTRL    : bit0 en_l, bit1 en_r, bit2 dir_l, bit3 dir_r
//   0x4 PERIOD  : [15:0] PWM period in clocks
//   0x8 DUTY    : [15:0] duty_l, [31:16] duty_r
//   0xC SCRATCH : storage only
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//   s00_axi_aw* / w* / b*          : write address, data, response channels
//   s00_axi_ar* / r*               : read address and data channels
//   pwm_l, pwm_r                   : PWM enables for left / right motor
//   dir_l, dir_r                   : direction for left / right motor
// -----------------------------------------------------------------------------
module motor_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            pwm_l,
  output logic                            pwm_r,
  output logic                            dir_l,
  output logic                            dir_r
);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Merge new data into old data one byte lane at a time.
  function automatic logic [31:0] f_apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Register file and channel state
  logic [31:0] r_regs [4];
  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;
  logic        r_awready, w_awready_nxt;
  logic        r_bvalid,  w_bvalid_nxt;
  logic        r_arready, w_arready_nxt;
  logic        r_rvalid,  w_rvalid_nxt;
  logic [31:0] r_rdata;

  // PWM state
  logic [15:0] r_cnt;
  logic [15:0] r_shadow;
  logic        r_pwm_l, r_pwm_r, r_dir_l, r_dir_r;

  logic        w_wr_en, w_rd_en;
  logic [1:0]  w_wr_idx, w_rd_idx;
  logic [15:0] w_period, w_duty_l, w_duty_r;
  logic        w_unused;

  // Byte-lane and protection inputs carry no meaning here.
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign w_wr_idx = s00_axi_awaddr[3:2];
  assign w_rd_idx = s00_axi_araddr[3:2];

  // The handshake edge is the one where the ready pulse meets still-held valids.
  assign w_wr_en = (r_wstate == W_IDLE) & r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_en = (r_rstate == R_IDLE) & r_arready & s00_axi_arvalid;

  assign w_period = r_regs[1][15:0];
  assign w_duty_l = r_regs[2][15:0];
  assign w_duty_r = r_regs[2][31:16];

  // Write channel next-state and ready/valid decode
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    case (r_wstate)
      W_IDLE: begin
        if (w_wr_en) begin
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
        end else if (!r_awready && s00_axi_awvalid && s00_axi_wvalid) begin
          w_awready_nxt = 1'b1;
        end else begin
          w_awready_nxt = 1'b0;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          w_wstate_nxt = W_IDLE;
          w_bvalid_nxt = 1'b0;
        end else begin
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
        w_bvalid_nxt = 1'b0;
      end
    endcase
  end

  // Write channel state register
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_bvalid  <= w_bvalid_nxt;
    end
  end

  // Register file with per-byte write enables
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 32'd0;
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= f_apply_strb(r_regs[w_wr_idx], s00_axi_wdata, s00_axi_wstrb);
    end
  end

  // Read channel next-state and ready/valid decode
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = r_rvalid;
    case (r_rstate)
      R_IDLE: begin
        if (w_rd_en) begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
        end else if (!r_arready && s00_axi_arvalid) begin
          w_arready_nxt = 1'b1;
        end else begin
          w_arready_nxt = 1'b0;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          w_rstate_nxt = R_IDLE;
          w_rvalid_nxt = 1'b0;
        end else begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
        w_rvalid_nxt = 1'b0;
      end
    endcase
  end

  // Read channel state and data register; rdata samples the pre-write value
  // when a write to the same word lands on the same edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_rd_en) r_rdata <= r_regs[w_rd_idx];
    end
  end

  // PWM counter; the shadow period only reloads at wrap (or while it is zero)
  // so a period change never cuts the running cycle short.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_cnt    <= 16'd0;
      r_shadow <= 16'd0;
    end else if (r_shadow == 16'd0) begin
      r_cnt    <= 16'd0;
      r_shadow <= w_period;
    end else if (r_cnt >= (r_shadow - 16'd1)) begin
      r_cnt    <= 16'd0;
      r_shadow <= w_period;
    end else begin
      r_cnt    <= r_cnt + 16'd1;
    end
  end

  // PWM and direction outputs; a zero shadow period forces PWM low.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_pwm_l <= 1'b0;
      r_pwm_r <= 1'b0;
      r_dir_l <= 1'b0;
      r_dir_r <= 1'b0;
    end else begin
      r_pwm_l <= r_regs[0][0] & (r_shadow != 16'd0) & (r_cnt < w_duty_l);
      r_pwm_r <= r_regs[0][1] & (r_shadow != 16'd0) & (r_cnt < w_duty_r);
      r_dir_l <= r_regs[0][2];
      r_dir_r <= r_regs[0][3];
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign pwm_l           = r_pwm_l;
  assign pwm_r           = r_pwm_r;
  assign dir_l           = r_dir_l;
  assign dir_r           = r_dir_r;

endmodule

// File: tb/tb_motor_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for motor_axi_lite_slave.
// -----------------------------------------------------------------------------
module tb_motor_axi_lite_slave;

  logic        s00_axi_aclk = 1'b0;
  logic        s00_axi_aresetn;
  logic [3:0]  s00_axi_awaddr;
  logic [2:0]  s00_axi_awprot;
  logic        s00_axi_awvalid;
  logic        s00_axi_awready;
  logic [31:0] s00_axi_wdata;
  logic [3:0]  s00_axi_wstrb;
  logic        s00_axi_wvalid;
  logic        s00_axi_wready;
  logic [1:0]  s00_axi_bresp;
  logic        s00_axi_bvalid;
  logic        s00_axi_bready;
  logic [3:0]  s00_axi_araddr;
  logic [2:0]  s00_axi_arprot;
  logic        s00_axi_arvalid;
  logic        s00_axi_arready;
  logic [31:0] s00_axi_rdata;
  logic [1:0]  s00_axi_rresp;
  logic        s00_axi_rvalid;
  logic        s00_axi_rready;
  logic        pwm_l, pwm_r, dir_l, dir_r;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  logic pwm_l_q = 1'b0;
  int rise_q[$];

  motor_axi_lite_slave dut (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_aresetn(s00_axi_aresetn),
    .s00_axi_awaddr (s00_axi_awaddr),
    .s00_axi_awprot (s00_axi_awprot),
    .s00_axi_awvalid(s00_axi_awvalid),
    .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata  (s00_axi_wdata),
    .s00_axi_wstrb  (s00_axi_wstrb),
    .s00_axi_wvalid (s00_axi_wvalid),
    .s00_axi_wready (s00_axi_wready),
    .s00_axi_bresp  (s00_axi_bresp),
    .s00_axi_bvalid (s00_axi_bvalid),
    .s00_axi_bready (s00_axi_bready),
    .s00_axi_araddr (s00_axi_araddr),
    .s00_axi_arprot (s00_axi_arprot),
    .s00_axi_arvalid(s00_axi_arvalid),
    .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata  (s00_axi_rdata),
    .s00_axi_rresp  (s00_axi_rresp),
    .s00_axi_rvalid (s00_axi_rvalid),
    .s00_axi_rready (s00_axi_rready),
    .pwm_l          (pwm_l),
    .pwm_r          (pwm_r),
    .dir_l          (dir_l),
    .dir_r          (dir_r)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  // Timestamp every rising edge of pwm_l in clock cycles.
  always @(negedge s00_axi_aclk) begin
    cyc = cyc + 1;
    if (pwm_l && !pwm_l_q) rise_q.push_back(cyc);
    pwm_l_q = pwm_l;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge s00_axi_aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    s00_axi_awaddr  = addr;
    s00_axi_wdata   = data;
    s00_axi_wstrb   = strb;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    s00_axi_bready  = 1'b1;
    n = 0;
    while (!(s00_axi_awready && s00_axi_wready) && n < 20) begin
      tick();
      n++;
    end
    chk("wr_ready_timeout", {31'd0, n < 20}, 32'd1);
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    n = 0;
    while (!s00_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    chk("wr_bvalid_timeout", {31'd0, n < 20}, 32'd1);
    resp = s00_axi_bresp;
    tick();
    s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    s00_axi_araddr  = addr;
    s00_axi_arvalid = 1'b1;
    s00_axi_rready  = 1'b1;
    n = 0;
    while (!s00_axi_arready && n < 20) begin
      tick();
      n++;
    end
    chk("rd_arready_timeout", {31'd0, n < 20}, 32'd1);
    tick();
    s00_axi_arvalid = 1'b0;
    n = 0;
    while (!s00_axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("rd_rvalid_timeout", {31'd0, n < 20}, 32'd1);
    data = s00_axi_rdata;
    resp = s00_axi_rresp;
    tick();
    s00_axi_rready = 1'b0;
  endtask

  task automatic count_pwm(input int ncyc, output int nl, output int nr);
    nl = 0;
    nr = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      nl += int'(pwm_l);
      nr += int'(pwm_r);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] held;
  logic [1:0]  rsp;
  int          nl, nr, n, d1, d2, d3;
  logic [3:0]  addrs [4];
  logic [31:0] vals  [4];

  initial begin
    s00_axi_aresetn = 1'b0;
    s00_axi_awaddr  = 4'h0;
    s00_axi_awprot  = 3'b000;
    s00_axi_awvalid = 1'b0;
    s00_axi_wdata   = 32'd0;
    s00_axi_wstrb   = 4'h0;
    s00_axi_wvalid  = 1'b0;
    s00_axi_bready  = 1'b0;
    s00_axi_araddr  = 4'h0;
    s00_axi_arprot  = 3'b000;
    s00_axi_arvalid = 1'b0;
    s00_axi_rready  = 1'b0;
    addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC;
    vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
    vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {31'd0, s00_axi_awready}, 32'd0);
    chk("rst_bvalid",  {31'd0, s00_axi_bvalid},  32'd0);
    chk("rst_arready", {31'd0, s00_axi_arready}, 32'd0);
    chk("rst_rvalid",  {31'd0, s00_axi_rvalid},  32'd0);
    chk("rst_rdata",   s00_axi_rdata, 32'd0);
    chk("rst_outs",    {28'd0, pwm_l, pwm_r, dir_l, dir_r}, 32'd0);
    s00_axi_aresetn = 1'b1;
    tick();

    // Register readback
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], vals[i], 4'hF, rsp);
      chk("wr_bresp", {30'd0, rsp}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], rd, rsp);
      chk("readback", rd, vals[i]);
      chk("rd_rresp", {30'd0, rsp}, 32'd0);
    end
    chk("dir_from_ctrl", {30'd0, dir_l, dir_r}, 32'd3);
    axi_read(4'h5, rd, rsp);
    chk("unaligned_read", rd, 32'hABCD0001);

    // Byte strobes
    axi_write(4'hC, 32'h00000000, 4'hF, rsp);
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0101, rsp);
    axi_read(4'hC, rd, rsp);
    chk("wstrb_0101", rd, 32'h00FF00FF);

    // Lone awvalid waits for wvalid
    s00_axi_awaddr  = 4'hC;
    s00_axi_wdata   = 32'h11112222;
    s00_axi_wstrb   = 4'hF;
    s00_axi_awvalid = 1'b1;
    s00_axi_bready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lone_aw_awready", {31'd0, s00_axi_awready}, 32'd0);
      chk("lone_aw_wready",  {31'd0, s00_axi_wready},  32'd0);
    end
    s00_axi_wvalid = 1'b1;
    tick();
    chk("aw_w_ready_pulse", {30'd0, s00_axi_awready, s00_axi_wready}, 32'd3);
    tick();
    chk("after_hs_awready", {31'd0, s00_axi_awready}, 32'd0);
    chk("after_hs_bvalid",  {31'd0, s00_axi_bvalid},  32'd1);
    // Second write offered while bready is held low
    s00_axi_wdata = 32'h33334444;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bstall_bvalid",  {31'd0, s00_axi_bvalid},  32'd1);
      chk("bstall_awready", {31'd0, s00_axi_awready}, 32'd0);
    end
    s00_axi_bready = 1'b1;
    tick();
    chk("bready_clears_bvalid", {31'd0, s00_axi_bvalid}, 32'd0);
    tick();
    chk("second_wr_awready", {31'd0, s00_axi_awready}, 32'd1);
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    chk("second_wr_bvalid", {31'd0, s00_axi_bvalid}, 32'd1);
    tick();
    s00_axi_bready = 1'b0;
    axi_read(4'hC, rd, rsp);
    chk("second_wr_data", rd, 32'h33334444);

    // Read with rready held low: rdata stays stable
    s00_axi_araddr  = 4'h4;
    s00_axi_arvalid = 1'b1;
    s00_axi_rready  = 1'b0;
    tick();
    chk("ar_pulse", {31'd0, s00_axi_arready}, 32'd1);
    tick();
    s00_axi_arvalid = 1'b0;
    chk("rvalid_latency", {31'd0, s00_axi_rvalid}, 32'd1);
    chk("rstall_first", s00_axi_rdata, 32'hABCD0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstall_rvalid", {31'd0, s00_axi_rvalid}, 32'd1);
      chk("rstall_rdata",  s00_axi_rdata, 32'hABCD0001);
    end
    s00_axi_rready = 1'b1;
    tick();
    chk("rready_clears_rvalid", {31'd0, s00_axi_rvalid}, 32'd0);
    s00_axi_rready = 1'b0;

    // Read and write to the same word on the same edge
    s00_axi_awaddr  = 4'hC;
    s00_axi_wdata   = 32'h55556666;
    s00_axi_wstrb   = 4'hF;
    s00_axi_araddr  = 4'hC;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    s00_axi_arvalid = 1'b1;
    s00_axi_bready  = 1'b1;
    s00_axi_rready  = 1'b1;
    tick();
    chk("same_edge_readies", {30'd0, s00_axi_awready, s00_axi_arready}, 32'd3);
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    s00_axi_arvalid = 1'b0;
    chk("same_edge_old_data", s00_axi_rdata, 32'h33334444);
    tick();
    s00_axi_bready = 1'b0;
    s00_axi_rready = 1'b0;
    axi_read(4'hC, rd, rsp);
    chk("same_edge_new_data", rd, 32'h55556666);

    // PWM 3/10 and 7/10
    axi_write(4'h4, 32'd10, 4'hF, rsp);
    axi_write(4'h8, 32'h00070003, 4'hF, rsp);
    axi_write(4'h0, 32'h00000003, 4'hF, rsp);
    repeat (12) tick();
    count_pwm(20, nl, nr);
    chk("pwm_l_3of10", nl, 32'd6);
    chk("pwm_r_7of10", nr, 32'd14);
    chk("dir_cleared", {30'd0, dir_l, dir_r}, 32'd0);

    // duty_l above period gives constant high
    axi_write(4'h8, 32'h0007000C, 4'hF, rsp);
    repeat (2) tick();
    count_pwm(20, nl, nr);
    chk("pwm_l_duty_ge_p", nl, 32'd20);
    chk("pwm_r_unchanged", nr, 32'd14);

    // Both disabled
    axi_write(4'h0, 32'h00000000, 4'hF, rsp);
    repeat (2) tick();
    count_pwm(20, nl, nr);
    chk("pwm_off_l", nl, 32'd0);
    chk("pwm_off_r", nr, 32'd0);

    // Period change 10 -> 4 mid-cycle
    axi_write(4'h8, 32'h00000001, 4'hF, rsp);
    axi_write(4'h0, 32'h00000001, 4'hF, rsp);
    repeat (12) tick();
    rise_q.delete();
    n = 0;
    while (rise_q.size() == 0 && n < 30) begin
      tick();
      n++;
    end
    chk("pwm_rise_timeout", {31'd0, n < 30}, 32'd1);
    axi_write(4'h4, 32'd4, 4'hF, rsp);
    repeat (30) tick();
    chk("rise_count_ge4", {31'd0, rise_q.size() >= 4}, 32'd1);
    d1 = (rise_q.size() >= 4) ? rise_q[1] - rise_q[0] : 0;
    d2 = (rise_q.size() >= 4) ? rise_q[2] - rise_q[1] : 0;
    d3 = (rise_q.size() >= 4) ? rise_q[3] - rise_q[2] : 0;
    chk("period_finish_10", d1, 32'd10);
    chk("period_new_4a", d2, 32'd4);
    chk("period_new_4b", d3, 32'd4);

    // Period 0 forces outputs low
    axi_write(4'h4, 32'd0, 4'hF, rsp);
    repeat (10) tick();
    count_pwm(12, nl, nr);
    chk("period0_pwm_l", nl, 32'd0);

    // Reset while bvalid is pending and PWM runs
    axi_write(4'h4, 32'd10, 4'hF, rsp);
    axi_write(4'h8, 32'h00050005, 4'hF, rsp);
    axi_write(4'h0, 32'h0000000F, 4'hF, rsp);
    repeat (12) tick();
    count_pwm(10, nl, nr);
    chk("pre_rst_pwm_l", nl, 32'd5);
    chk("pre_rst_dir", {30'd0, dir_l, dir_r}, 32'd3);
    s00_axi_awaddr  = 4'hC;
    s00_axi_wdata   = 32'h77778888;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    s00_axi_bready  = 1'b0;
    tick();
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    chk("pre_rst_bvalid", {31'd0, s00_axi_bvalid}, 32'd1);
    #2;
    s00_axi_aresetn = 1'b0;
    #1;
    chk("async_rst_bvalid", {31'd0, s00_axi_bvalid}, 32'd0);
    chk("async_rst_rdata",  s00_axi_rdata, 32'd0);
    chk("async_rst_outs",   {28'd0, pwm_l, pwm_r, dir_l, dir_r}, 32'd0);
    #3;
    s00_axi_aresetn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], rd, rsp);
      chk("post_rst_reg", rd, 32'd0);
    end
    count_pwm(10, nl, nr);
    chk("post_rst_pwm", nl + nr, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
